// File: rtl/spinner_multi_if.sv
// spinner_multi_if: bundles the dial controls, spinner samples and angle outputs of spinner_multi.
// Latency: none; this is wiring only.
// Backpressure: none; all signals are level/pulse qualified, no handshake.
interface spinner_multi_if #(
   parameter int CH    = 2,
   parameter int OUT_W = 4
);
   logic                  strobe;
   logic [CH-1:0]         plus;
   logic [CH-1:0]         minus;
   logic [CH-1:0]         fast;
   logic [CH-1:0]         clamp;
   logic [9*CH-1:0]       spin_in;
   logic [CH-1:0]         load;
   logic [OUT_W*CH-1:0]   load_val;
   logic [OUT_W*CH-1:0]   spin_out;
   logic [CH-1:0]         step_pulse;

   modport master (
      output strobe, plus, minus, fast, clamp, spin_in, load, load_val,
      input  spin_out, step_pulse
   );

   modport slave (
      input  strobe, plus, minus, fast, clamp, spin_in, load, load_val,
      output spin_out, step_pulse
   );
endinterface

// File: rtl/spinner_multi.sv
// spinner_multi: per-channel dial angle driven by strobe-paced buttons and optional spinner deltas.
// Latency: 1 clk from strobe rising edge / spinner toggle to spin_out and step_pulse.
// Backpressure: none; every event is absorbed in the cycle it is seen.
// Build option: define SPINNER_MULTI_SPIN_EN to include the spinner accumulator path (SPIN_SHIFT >= 1).
module spinner_multi #(
   parameter int CH         = 2,
   parameter int OUT_W      = 4,
   parameter int SLOW_DIV   = 4,
   parameter int SPIN_SHIFT = 2
) (
   input logic             clk,
   input logic             reset,
   spinner_multi_if.slave  bus
);
   localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam int AW = 9 + SPIN_SHIFT;                       // spinner accumulator width
   localparam int SW = AW + 1;                               // combined step width
   localparam int NW = ((OUT_W > SW) ? OUT_W : SW) + 2;      // headroom for over/underflow detect
   localparam logic [CW-1:0] SLOW_LIM = CW'(SLOW_DIV - 1);

   logic                   strobe_d;
   logic                   sev;
   logic [OUT_W-1:0]       angle_q [CH];
   logic [OUT_W-1:0]       angle_n [CH];
   logic [CW-1:0]          cnt_q   [CH];
   logic [CW-1:0]          cnt_n   [CH];
   logic [CH-1:0]          pulse_q;
   logic [CH-1:0]          pulse_n;
   logic [CH-1:0]          spin_ev;
   logic signed [AW-1:0]   sstep   [CH];
   logic signed [SW-1:0]   dstep   [CH];
   logic signed [SW-1:0]   delta   [CH];
   logic signed [NW-1:0]   sum     [CH];

   // One rising-edge detector shared by every channel.
   assign sev = bus.strobe & ~strobe_d;

`ifdef SPINNER_MULTI_SPIN_EN
   logic [CH-1:0]          tog_q;
   logic [SPIN_SHIFT-1:0]  res_q [CH];
   logic [SPIN_SHIFT-1:0]  res_n [CH];
   logic signed [AW-1:0]   acc   [CH];

   // Fold the new delta into the residue, split into whole angle steps plus a non-negative remainder.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         spin_ev[c] = bus.spin_in[9*c+8] ^ tog_q[c];
         acc[c]     = {{(AW-SPIN_SHIFT){1'b0}}, res_q[c]}
                    + {{(AW-8){bus.spin_in[9*c+7]}}, bus.spin_in[9*c +: 8]};
         sstep[c]   = acc[c] >>> SPIN_SHIFT;
         // acc - (step << SPIN_SHIFT) is exactly the low SPIN_SHIFT bits of acc.
         res_n[c]   = res_q[c];
         if (bus.load[c]) begin
            res_n[c] = '0;
         end else if (spin_ev[c]) begin
            res_n[c] = acc[c][SPIN_SHIFT-1:0];
         end
      end
   end

   // Toggle follows spin_in every cycle; residue moves only on events or load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tog_q <= '0;
         for (int c = 0; c < CH; c++) res_q[c] <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            tog_q[c] <= bus.spin_in[9*c+8];
            res_q[c] <= res_n[c];
         end
      end
   end
`else
   logic unused_spin;

   // Spinner path absent: the port is kept but contributes no steps.
   assign unused_spin = ^bus.spin_in;
   assign spin_ev     = '0;

   // No spinner steps in this build.
   always_comb begin
      for (int c = 0; c < CH; c++) sstep[c] = '0;
   end
`endif

   // Per-channel next angle: paced digital step plus spinner step, then wrap or saturate; load wins.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         dstep[c] = '0;
         cnt_n[c] = cnt_q[c];
         if (sev) begin
            if (bus.plus[c] ^ bus.minus[c]) begin
               if (cnt_q[c] >= (bus.fast[c] ? CW'(0) : SLOW_LIM)) begin
                  dstep[c] = bus.plus[c] ? SW'(1) : '1;
                  cnt_n[c] = '0;
               end else begin
                  cnt_n[c] = cnt_q[c] + CW'(1);
               end
            end else begin
               cnt_n[c] = '0;
            end
         end

         delta[c] = dstep[c] + (spin_ev[c] ? {sstep[c][AW-1], sstep[c]} : '0);
         sum[c]   = {{(NW-OUT_W){1'b0}}, angle_q[c]} + {{(NW-SW){delta[c][SW-1]}}, delta[c]};

         angle_n[c] = angle_q[c];
         if (bus.load[c]) begin
            angle_n[c] = bus.load_val[c*OUT_W +: OUT_W];
            cnt_n[c]   = '0;
         end else if (sev | spin_ev[c]) begin
            if (!bus.clamp[c]) begin
               angle_n[c] = sum[c][OUT_W-1:0];
            end else if (sum[c][NW-1]) begin
               angle_n[c] = '0;
            end else if (|sum[c][NW-2:OUT_W]) begin
               angle_n[c] = '1;
            end else begin
               angle_n[c] = sum[c][OUT_W-1:0];
            end
         end
         pulse_n[c] = (angle_n[c] != angle_q[c]);
      end
   end

   // Register strobe history, angles, dividers and the change pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         strobe_d <= 1'b0;
         pulse_q  <= '0;
         for (int c = 0; c < CH; c++) begin
            angle_q[c] <= '0;
            cnt_q[c]   <= '0;
         end
      end else begin
         strobe_d <= bus.strobe;
         pulse_q  <= pulse_n;
         for (int c = 0; c < CH; c++) begin
            angle_q[c] <= angle_n[c];
            cnt_q[c]   <= cnt_n[c];
         end
      end
   end

   // Flatten the registered angles onto the output bus.
   always_comb begin
      bus.spin_out = '0;
      for (int c = 0; c < CH; c++) bus.spin_out[c*OUT_W +: OUT_W] = angle_q[c];
   end

   assign bus.step_pulse = pulse_q;
endmodule

// File: doc/spinner_multi.md
SPINNER_MULTI -- requirements
Module: spinner_multi

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent dial channels.
REQ-002 SHALL have parameter OUT_W, default 4: angle width per channel.
REQ-003 SHALL have parameter SLOW_DIV, default 4: strobe events per digital step in slow mode.
REQ-004 SHALL have parameter SPIN_SHIFT, default 2: spinner counts per angle step, expressed as 2^SPIN_SHIFT.
REQ-005 SHALL have these ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- strobe  in  1  frame pacing (vsync); only its rising edge is used.
- plus  in  CH  per-channel clockwise button.
- minus  in  CH  per-channel counter-clockwise button.
- fast  in  CH  per-channel fast-mode select.
- clamp  in  CH  per-channel mode: 1 = saturate, 0 = wrap.
- spin_in  in  9*CH  per channel: [7:0] signed delta, [8] new-sample toggle.
- load  in  CH  per-channel synchronous preset.
- load_val  in  OUT_W*CH  preset values.
- spin_out  out  OUT_W*CH  registered angles.
- step_pulse  out  CH  1-cycle pulse when a channel's angle changed.

Function
REQ-006 SHALL register strobe as strobe_d; strobe event (sev) = strobe & ~strobe_d, shared by all channels.
REQ-007 Per channel, SHALL keep a divider counter (width to hold SLOW_DIV-1), reset to 0.
REQ-008 On sev with plus^minus = 1, SHALL step when the counter reaches the limit (fast ? 0 : SLOW_DIV-1): +1 for plus, -1 for minus, counter cleared; otherwise the counter increments.
REQ-009 On sev with plus==minus (both or neither), SHALL clear the counter and not step.
REQ-010 SHALL flag a spinner event when spin_in[8] differs from the stored toggle (reset 0); the stored toggle updates every cycle.
REQ-011 On a spinner event, SHALL form acc = residue + sign-extended delta (signed, 9+SPIN_SHIFT bits).
REQ-012 SHALL take the spinner step as acc >>> SPIN_SHIFT (arithmetic shift), and the new residue as acc - (step << SPIN_SHIFT), which is always in 0..2^SPIN_SHIFT-1.
REQ-013 Digital and spinner steps in the same cycle SHALL be summed into one signed delta before it is applied.
REQ-014 In wrap mode (clamp=0), SHALL compute the new angle modulo 2^OUT_W.
REQ-015 In saturate mode (clamp=1), SHALL limit the new angle to 0..2^OUT_W-1.
REQ-016 load SHALL have top priority: the angle becomes load_val, and the counter and residue clear; any step in that cycle is discarded.
REQ-017 spin_out SHALL update on the clock edge that ends the cycle in which sev or a spinner event is detected; latency is 1 clk.
REQ-018 step_pulse SHALL assert for exactly one cycle, coincident with spin_out updating, only if the new value differs from the old; a saturated no-change gives no pulse.
REQ-019 Channels SHALL be fully independent, apart from the shared strobe edge detector.

Reset
REQ-020 While reset is high, SHALL hold spin_out=0, step_pulse=0, counters=0, residues=0, stored toggles=0, strobe_d=0, asynchronously and immediately, including mid-operation.
REQ-021 After reset deasserts, the first strobe high-sample SHALL count as an edge.

Configuration
REQ-022 Macro SPINNER_MULTI_SPIN_EN SHALL compile in the spinner path (REQ-010..REQ-012).
REQ-023 With SPINNER_MULTI_SPIN_EN undefined: spin_in stays a port but is ignored, no residue or toggle registers exist, and only digital stepping occurs.

Verification (CH=2, OUT_W=4, SLOW_DIV=4, SPIN_SHIFT=2, SPIN_EN defined)
REQ-024 Reset, then release with strobe idle -> spin_out=0x00, step_pulse=00.
REQ-025 plus[0]=1, fast=0, 8 strobe edges -> ch0=2 (steps on edges 4 and 8), ch1=0, two step_pulse[0] pulses.
REQ-026 Load ch0=15, fast[0]=1, plus[0]=1, one edge -> clamp=0 gives 0 with a pulse; clamp=1 stays 15 with no pulse.
REQ-027 ch1 spinner from 0:
- delta +6 with toggle -> ch1=1, residue 2.
- then +2 with toggle -> ch1=2, residue 0.
- then 0xFB (-5) with toggle -> ch1=0, residue 3.
- same delta with toggle unchanged -> no change.
REQ-028 load[0] with load_val=9, coincident with an sev and plus[0] (fast) -> ch0=9; next edge -> 10.
REQ-029 Assert reset asynchronously between clock edges while counting -> outputs go to 0 before the next clk edge; counting restarts from 0 after release.
